frame_streamer: RTL and testbench

Frame-buffer reader and pixel-stream transmitter. On a start pulse it reads one FRAME_WIDTH x FRAME_HEIGHT RGB frame from a synchronous-read RAM in raster order. It emits the frame on the pixel-stream interface (pix_val/sof/eof/sol/eol/data) consumed by the grayscale stage. Programmable horizontal blanking separates lines. It is the source end of the pixel-stream protocol.

---
 rtl/frame_streamer.sv | 198 +++++++++++++++++++
 tb/tb_frame_streamer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_streamer.sv
// frame_streamer: frame-buffer reader and pixel-stream source.
// On a start pulse it reads one FRAME_WIDTH x FRAME_HEIGHT frame in raster
// order from a synchronous-read RAM. It emits the frame on the pixel-stream
// interface, with HBLANK idle cycles between lines.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle request to stream a frame (ignored while busy)
//   abort           synchronous abort of the frame in progress
//   busy            frame in progress (start accepted .. eof pixel inclusive)
//   done            one-cycle pulse in the cycle after the eof pixel
//   mem_rd_en       RAM read strobe
//   mem_rd_addr     RAM read address, raster order
//   mem_rd_data     RAM read data, valid one cycle after mem_rd_en
//   pix_val         pixel valid
//   pix_sof/eof     first / last pixel of the frame
//   pix_sol/eol     first / last pixel of each line
//   pix_data        pixel RGB value (holds while pix_val=0)
module frame_streamer #(
  parameter int unsigned FRAME_WIDTH  = 640,
  parameter int unsigned FRAME_HEIGHT = 480,
  parameter int unsigned PIX_WIDTH    = 24,
  parameter int unsigned HBLANK       = 4,
  parameter int unsigned AW           = $clog2(FRAME_WIDTH * FRAME_HEIGHT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_rd_en,
  output logic [AW-1:0]        mem_rd_addr,
  input  logic [PIX_WIDTH-1:0] mem_rd_data,
  output logic                 pix_val,
  output logic                 pix_sof,
  output logic                 pix_eof,
  output logic                 pix_sol,
  output logic                 pix_eol,
  output logic [PIX_WIDTH-1:0] pix_data
);

  localparam int unsigned XW = (FRAME_WIDTH > 2) ? $clog2(FRAME_WIDTH) : 1;
  localparam int unsigned YW = (FRAME_HEIGHT > 2) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int unsigned HW = (HBLANK > 2) ? $clog2(HBLANK) : 1;

  localparam logic [XW-1:0] X_LAST  = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(FRAME_HEIGHT - 1);
  localparam logic [AW-1:0] A_LAST  = AW'(FRAME_WIDTH * FRAME_HEIGHT - 1);
  localparam logic [HW-1:0] HB_LAST = HW'((HBLANK == 0) ? 0 : HBLANK - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_HBLANK = 2'd2,
    S_FLUSH  = 2'd3
  } state_t;

  // Position flags of one pixel, carried alongside the RAM read.
  typedef struct packed {
    logic sof;
    logic sol;
    logic eol;
    logic eof;
  } flags_t;

  state_t          state;
  logic [XW-1:0]   x_cnt;
  logic [YW-1:0]   y_cnt;
  logic [HW-1:0]   hb_cnt;
  logic            flush_cnt;
  logic            s1_val;
  flags_t          s1_flags;
  logic            abort_hit_c;

  // Abort only acts on a frame in progress.
  assign abort_hit_c = abort && (state != S_IDLE);

  // Frame sequencer, read-address generator and two-stage output pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      x_cnt       <= '0;
      y_cnt       <= '0;
      hb_cnt      <= '0;
      flush_cnt   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      s1_val      <= 1'b0;
      s1_flags    <= '0;
      pix_val     <= 1'b0;
      pix_sof     <= 1'b0;
      pix_eof     <= 1'b0;
      pix_sol     <= 1'b0;
      pix_eol     <= 1'b0;
      pix_data    <= '0;
    end else if (abort_hit_c) begin
      // Drop everything in flight; pix_data keeps the last shown pixel.
      state       <= S_IDLE;
      x_cnt       <= '0;
      y_cnt       <= '0;
      hb_cnt      <= '0;
      flush_cnt   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      s1_val      <= 1'b0;
      s1_flags    <= '0;
      pix_val     <= 1'b0;
      pix_sof     <= 1'b0;
      pix_eof     <= 1'b0;
      pix_sol     <= 1'b0;
      pix_eol     <= 1'b0;
    end else begin
      done     <= 1'b0;
      s1_val   <= 1'b0;
      s1_flags <= '0;

      // Output stage: stage-1 flags meet the RAM data here.
      pix_val <= s1_val;
      pix_sof <= s1_flags.sof;
      pix_eof <= s1_flags.eof;
      pix_sol <= s1_flags.sol;
      pix_eol <= s1_flags.eol;
      if (s1_val) begin
        pix_data <= mem_rd_data;
      end

      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state     <= S_READ;
            busy      <= 1'b1;
            mem_rd_en <= 1'b1;
          end
        end

        S_READ: begin
          s1_val       <= 1'b1;
          s1_flags.sof <= (x_cnt == '0) && (y_cnt == '0);
          s1_flags.sol <= (x_cnt == '0);
          s1_flags.eol <= (x_cnt == X_LAST);
          s1_flags.eof <= (x_cnt == X_LAST) && (y_cnt == Y_LAST);

          // Address wraps to 0 after the last pixel of the frame.
          mem_rd_addr <= (mem_rd_addr == A_LAST) ? '0 : mem_rd_addr + 1'b1;

          if (x_cnt == X_LAST) begin
            x_cnt <= '0;
            if (y_cnt == Y_LAST) begin
              y_cnt     <= '0;
              state     <= S_FLUSH;
              flush_cnt <= 1'b0;
              mem_rd_en <= 1'b0;
            end else begin
              y_cnt <= y_cnt + 1'b1;
              if (HBLANK != 0) begin
                state     <= S_HBLANK;
                hb_cnt    <= '0;
                mem_rd_en <= 1'b0;
              end
            end
          end else begin
            x_cnt <= x_cnt + 1'b1;
          end
        end

        S_HBLANK: begin
          if (hb_cnt == HB_LAST) begin
            state     <= S_READ;
            mem_rd_en <= 1'b1;
          end else begin
            hb_cnt <= hb_cnt + 1'b1;
          end
        end

        S_FLUSH: begin
          // Two cycles: last pixel moves through both pipeline stages.
          if (flush_cnt) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            flush_cnt <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_streamer.sv
// Bench for frame_streamer (4x3 frame, HBLANK=2). The reference model
// derives every output from the accepted start cycle with plain arithmetic
// on the line period; directed phases pin the model with literal cycles.
module tb_frame_streamer;

  localparam int unsigned W    = 4;
  localparam int unsigned H    = 3;
  localparam int unsigned HB   = 2;
  localparam int unsigned PW   = 24;
  localparam int unsigned NPIX = W * H;
  localparam int unsigned AW   = $clog2(NPIX);
  localparam int          P    = W + HB;
  localparam int          INF  = 32'h3fff_ffff;
  localparam int          LOGN = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [PW-1:0] mem_rd_data;
  logic          pix_val, pix_sof, pix_eof, pix_sol, pix_eol;
  logic [PW-1:0] pix_data;

  logic [PW-1:0] mem [NPIX];

  frame_streamer #(
    .FRAME_WIDTH (W),
    .FRAME_HEIGHT(H),
    .PIX_WIDTH   (PW),
    .HBLANK      (HB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .pix_val    (pix_val),
    .pix_sof    (pix_sof),
    .pix_eof    (pix_eof),
    .pix_sol    (pix_sol),
    .pix_eol    (pix_eol),
    .pix_data   (pix_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en && (int'(mem_rd_addr) < NPIX)) mem_rd_data <= mem[int'(mem_rd_addr)];
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model state: at most one frame of interest at a time.
  bit            has_frame = 1'b0;
  int            t0 = 0;
  int            cut = INF;
  bit            m_busy = 1'b0;
  logic [PW-1:0] exp_data = '0;

  // Per-phase log indexed by cycle relative to s_base.
  int   s_base = 0;
  logic l_val [LOGN], l_sof [LOGN], l_eof [LOGN], l_sol [LOGN], l_eol [LOGN];
  logic l_busy [LOGN], l_done [LOGN], l_rd [LOGN];
  int   l_addr [LOGN];
  logic [PW-1:0] l_data [LOGN];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic check_cycle();
    logic e_busy, e_done, e_rd, e_val, e_sof, e_eof, e_sol, e_eol;
    int e_addr, k, l, x, last;
    e_busy = 0; e_done = 0; e_rd = 0; e_val = 0;
    e_sof = 0; e_eof = 0; e_sol = 0; e_eol = 0; e_addr = 0;
    if (has_frame && rst_n) begin
      last = t0 + 3 + (H - 1) * P + W - 1;
      if (cyc <= cut) begin
        e_busy = (cyc >= t0 + 1) && (cyc <= last);
        e_done = (cyc == last + 1);
        k = cyc - t0 - 1;
        if (k >= 0) begin
          l = k / P; x = k % P;
          if (l < H && x < W) begin e_rd = 1; e_addr = l * W + x; end
        end
        k = cyc - t0 - 3;
        if (k >= 0) begin
          l = k / P; x = k % P;
          if (l < H && x < W) begin
            e_val = 1;
            e_sof = (l == 0) && (x == 0);
            e_sol = (x == 0);
            e_eol = (x == W - 1);
            e_eof = (x == W - 1) && (l == H - 1);
            exp_data = mem[l * W + x];
          end
        end
      end
    end
    m_busy = e_busy;
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
    if (e_rd || !e_busy) chk("mem_rd_addr", 32'(mem_rd_addr), 32'(e_addr));
    chk("pix_val", 32'(pix_val), 32'(e_val));
    chk("pix_sof", 32'(pix_sof), 32'(e_sof));
    chk("pix_eof", 32'(pix_eof), 32'(e_eof));
    chk("pix_sol", 32'(pix_sol), 32'(e_sol));
    chk("pix_eol", 32'(pix_eol), 32'(e_eol));
    chk("pix_data", 32'(pix_data), 32'(exp_data));
  endtask

  // Called at a falling edge: check, log, drive inputs, advance one cycle.
  task automatic step(input logic st, input logic ab);
    int rel;
    check_cycle();
    rel = cyc - s_base;
    if (rel >= 0 && rel < LOGN) begin
      l_val[rel] = pix_val;  l_sof[rel] = pix_sof; l_eof[rel] = pix_eof;
      l_sol[rel] = pix_sol;  l_eol[rel] = pix_eol; l_busy[rel] = busy;
      l_done[rel] = done;    l_rd[rel] = mem_rd_en;
      l_addr[rel] = int'(mem_rd_addr); l_data[rel] = pix_data;
    end
    start = st;
    abort = ab;
    if (rst_n) begin
      if (ab && m_busy) cut = cyc;
      else if (st && !ab && !m_busy) begin has_frame = 1; t0 = cyc; cut = INF; end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic new_phase();
    s_base = cyc;
    for (int r = 0; r < LOGN; r++) begin
      l_val[r] = 0; l_sof[r] = 0; l_eof[r] = 0; l_sol[r] = 0; l_eol[r] = 0;
      l_busy[r] = 0; l_done[r] = 0; l_rd[r] = 0; l_addr[r] = 0; l_data[r] = '0;
    end
  endtask

  initial begin
    int n, idx, first;
    logic e;

    for (int i = 0; i < NPIX; i++) mem[i] = PW'(i * 32'h010101);
    @(negedge clk);
    // Reset state while rst_n is held low.
    for (int i = 0; i < 3; i++) step(0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0);

    // Phase 1: one frame, mid-frame start ignored, back-to-back start at done.
    new_phase();
    for (int r = 0; r < 60; r++) step(r == 0 || r == 8 || r == 19, 0);

    first = -1;
    for (int r = 0; r < 20; r++) if (l_val[r] === 1'b1 && first < 0) first = r;
    chk("p1_first_pix_cycle", 32'(first), 32'd3);
    n = 0;
    for (int r = 0; r < 20; r++) begin
      e = (r >= 3 && r <= 6) || (r >= 9 && r <= 12) || (r >= 15 && r <= 18);
      if (l_val[r] !== e) n++;
    end
    chk("p1_pix_val_cycles", 32'(n), 32'd0);
    n = 0; idx = 0;
    for (int r = 0; r < 20; r++) begin
      e = (r >= 1 && r <= 4) || (r >= 7 && r <= 10) || (r >= 13 && r <= 16);
      if (l_rd[r] !== e) n++;
      if (l_rd[r] === 1'b1) begin
        if (l_addr[r] != idx) n++;
        idx++;
      end
    end
    chk("p1_rd_cycles_addr", 32'(n), 32'd0);
    n = 0;
    for (int r = 0; r < 20; r++) begin
      if (l_sof[r] !== (r == 3)) n++;
      if (l_sol[r] !== (r == 3 || r == 9 || r == 15)) n++;
      if (l_eol[r] !== (r == 6 || r == 12 || r == 18)) n++;
      if (l_eof[r] !== (r == 18)) n++;
    end
    chk("p1_flag_cycles", 32'(n), 32'd0);
    n = 0;
    for (int r = 0; r < 20; r++) begin
      if (l_done[r] !== (r == 19)) n++;
      if (l_busy[r] !== (r >= 1 && r <= 18)) n++;
    end
    chk("p1_busy_done_cycles", 32'(n), 32'd0);
    n = 0; idx = 0;
    for (int r = 0; r < 20; r++) begin
      if (l_val[r] === 1'b1) begin
        if (l_data[r] !== PW'(idx * 32'h010101)) n++;
        idx++;
      end
    end
    chk("p1_data_sequence", 32'(n), 32'd0);
    chk("p1_pixel_count", 32'(idx), 32'd12);
    first = -1;
    for (int r = 20; r < LOGN; r++) if (l_val[r] === 1'b1 && first < 0) first = r;
    chk("p1_second_frame_first_pix", 32'(first), 32'd22);

    // Phase 2: abort mid-frame, restart, then start+abort together in idle.
    for (int i = 0; i < NPIX; i++) mem[i] = PW'($urandom);
    new_phase();
    for (int r = 0; r < 60; r++) step(r == 0 || r == 25 || r == 50, r == 10 || r == 50);
    chk("p2_busy_after_abort", 32'(l_busy[11]), 32'd0);
    chk("p2_val_after_abort", 32'(l_val[11]), 32'd0);
    n = 0;
    for (int r = 0; r < 25; r++) if (l_done[r] === 1'b1 || l_eof[r] === 1'b1) n++;
    chk("p2_no_eof_done_after_abort", 32'(n), 32'd0);
    chk("p2_restart_addr0", 32'(l_rd[26] === 1'b1 && l_addr[26] == 0), 32'd1);
    chk("p2_restart_done_cycle", 32'(l_done[44]), 32'd1);
    chk("p2_start_abort_idle", 32'(l_busy[51]), 32'd0);

    // Phase 3: asynchronous reset in the middle of a frame.
    new_phase();
    for (int r = 0; r < 9; r++) step(r == 0, 0);
    check_cycle();
    rst_n = 1'b0;
    #1;
    has_frame = 0; m_busy = 0; exp_data = '0;
    chk("p3_rst_busy", 32'(busy), 32'd0);
    chk("p3_rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("p3_rst_val", 32'(pix_val), 32'd0);
    chk("p3_rst_flags", 32'({pix_sof, pix_eof, pix_sol, pix_eol}), 32'd0);
    chk("p3_rst_data", 32'(pix_data), 32'd0);
    @(posedge clk); cyc++; @(negedge clk);
    check_cycle();
    @(posedge clk); cyc++; @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 30; r++) step(0, 0);
    n = 0;
    for (int r = 11; r < 41; r++) if (l_val[r] === 1'b1 || l_done[r] === 1'b1) n++;
    chk("p3_silent_after_reset", 32'(n), 32'd0);

    // Phase 4: random start/abort traffic against the model.
    for (int i = 0; i < NPIX; i++) mem[i] = PW'($urandom);
    for (int r = 0; r < 3000; r++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0);
    for (int r = 0; r < 30; r++) step(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
